// File: rtl/br_ctrl_pkg.sv
// Shared types for the branch resolution controller: FSM states and the
// predictor-update entry layout.
package br_ctrl_pkg;

    localparam int PC_W_DEFAULT = 32;

    typedef enum logic [1:0] {
        IDLE,
        REDIRECT,
        DRAIN
    } state_e;

    typedef struct packed {
        logic [PC_W_DEFAULT-1:0] pc;
        logic                    taken;
        logic [PC_W_DEFAULT-1:0] target;
    } upd_entry_t;

endpackage

// File: rtl/branch_resolve_ctrl_if.sv
// EX-stage / fetch / predictor signal bundle of the branch resolution controller.
// The slave modport is the controller's view; master is the surrounding pipeline.
interface branch_resolve_ctrl_if
    import br_ctrl_pkg::*;
#(
    parameter int PC_W = PC_W_DEFAULT
);
    logic            ex_valid;
    logic            ex_branch;
    logic [PC_W-1:0] ex_pc;
    logic            ex_taken;
    logic [PC_W-1:0] ex_target;
    logic            ex_pred_hit;
    logic            ex_pred_taken;
    logic [PC_W-1:0] ex_pred_target;
    logic            upd_ready;
    logic            stall_req;
    logic            redirect_valid;
    logic [PC_W-1:0] redirect_pc;
    logic            flush_if_id;
    logic            flush_id_ex;
    logic            upd_valid;
    logic [PC_W-1:0] upd_pc;
    logic            upd_taken;
    logic [PC_W-1:0] upd_target;
    logic            busy;
    logic [31:0]     perf_branches;
    logic [31:0]     perf_mispred;

    modport slave (
        input  ex_valid, ex_branch, ex_pc, ex_taken, ex_target,
               ex_pred_hit, ex_pred_taken, ex_pred_target, upd_ready,
        output stall_req, redirect_valid, redirect_pc, flush_if_id, flush_id_ex,
               upd_valid, upd_pc, upd_taken, upd_target, busy,
               perf_branches, perf_mispred
    );

    modport master (
        output ex_valid, ex_branch, ex_pc, ex_taken, ex_target,
               ex_pred_hit, ex_pred_taken, ex_pred_target, upd_ready,
        input  stall_req, redirect_valid, redirect_pc, flush_if_id, flush_id_ex,
               upd_valid, upd_pc, upd_taken, upd_target, busy,
               perf_branches, perf_mispred
    );
endinterface

// File: rtl/br_upd_fifo.sv
// Synchronous FIFO of predictor-update entries. The head is read from storage
// flops only, so head_o has no combinational path from the inputs.
module br_upd_fifo
    import br_ctrl_pkg::*;
#(
    parameter int  DEPTH   = 4,
    parameter type entry_t = upd_entry_t
) (
    input  logic   clk,
    input  logic   reset,
    input  logic   push_i,
    input  entry_t push_data_i,
    input  logic   pop_i,
    output logic   full_o,
    output logic   empty_o,
    output entry_t head_o
);
    localparam int AW = $clog2(DEPTH);

    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW:0]   count_q;
    entry_t        mem_q [DEPTH];
    logic          do_push;
    logic          do_pop;

    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    // NOTE: sequential state uses <= so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: ;
            endcase
        end
    end

    // NOTE: storage is not reset; the empty gate below keeps stale data off the outputs.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data_i;
    end

    assign head_o = empty_o ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/branch_resolve_ctrl.sv
// Branch resolution controller: mispredict detection, PC redirect/flush FSM and
// predictor-update queue. Optional performance counters under BR_PERF_CNT_EN.
module branch_resolve_ctrl
    import br_ctrl_pkg::*;
#(
    parameter int PC_W         = PC_W_DEFAULT,
    parameter int UPD_DEPTH    = 4,
    parameter int DRAIN_CYCLES = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    branch_resolve_ctrl_if.slave bus
);
    localparam int CNT_W = $clog2(DRAIN_CYCLES + 1);

    // Same layout as the package entry, sized by this instance's PC_W.
    typedef struct packed {
        logic [PC_W-1:0] pc;
        logic            taken;
        logic [PC_W-1:0] target;
    } upd_t;

    state_e          state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [PC_W-1:0] redirect_pc_q, redirect_pc_d;
    logic [PC_W-1:0] pc_plus4, pred_next, act_next;
    logic            resolve, mispredict, take_redirect;
    logic            fifo_full, fifo_empty, push, pop;
    upd_t            push_entry, head;

    // Branches arriving during REDIRECT or DRAIN are wrong-path.
    assign resolve       = bus.ex_valid & bus.ex_branch & (state_q == IDLE);
    assign pc_plus4      = bus.ex_pc + PC_W'(4);
    assign pred_next     = (bus.ex_pred_hit & bus.ex_pred_taken) ? bus.ex_pred_target : pc_plus4;
    assign act_next      = bus.ex_taken ? bus.ex_target : pc_plus4;
    assign mispredict    = resolve & (pred_next != act_next);
    assign push          = resolve & ~fifo_full;
    assign take_redirect = mispredict & ~fifo_full;
    assign pop           = ~fifo_empty & bus.upd_ready;
    assign push_entry    = upd_t'{pc: bus.ex_pc, taken: bus.ex_taken, target: bus.ex_target};

    br_upd_fifo #(
        .DEPTH   (UPD_DEPTH),
        .entry_t (upd_t)
    ) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .push_i      (push),
        .push_data_i (push_entry),
        .pop_i       (pop),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .head_o      (head)
    );

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        redirect_pc_d = redirect_pc_q;
        case (state_q)
            IDLE: begin
                if (take_redirect) begin
                    state_d       = REDIRECT;
                    redirect_pc_d = act_next;
                end
            end
            REDIRECT: begin
                state_d = DRAIN;
                cnt_d   = CNT_W'(DRAIN_CYCLES - 1);
            end
            DRAIN: begin
                if (cnt_q == '0) state_d = IDLE;
                else             cnt_d   = cnt_q - CNT_W'(1);
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            redirect_pc_q <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            redirect_pc_q <= redirect_pc_d;
        end
    end

    assign bus.stall_req      = resolve & fifo_full;
    assign bus.redirect_valid = (state_q == REDIRECT);
    assign bus.flush_if_id    = (state_q == REDIRECT);
    assign bus.flush_id_ex    = (state_q == REDIRECT);
    assign bus.redirect_pc    = redirect_pc_q;
    assign bus.upd_valid      = ~fifo_empty;
    assign bus.upd_pc         = head.pc;
    assign bus.upd_taken      = head.taken;
    assign bus.upd_target     = head.target;
    assign bus.busy           = (state_q != IDLE) | ~fifo_empty;

`ifdef BR_PERF_CNT_EN
    logic [31:0] perf_branches_q;
    logic [31:0] perf_mispred_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            perf_branches_q <= '0;
            perf_mispred_q  <= '0;
        end else begin
            if (push)          perf_branches_q <= perf_branches_q + 32'd1;
            if (take_redirect) perf_mispred_q  <= perf_mispred_q + 32'd1;
        end
    end

    assign bus.perf_branches = perf_branches_q;
    assign bus.perf_mispred  = perf_mispred_q;
`else
    assign bus.perf_branches = '0;
    assign bus.perf_mispred  = '0;
`endif

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// Directed testbench for branch_resolve_ctrl (PC_W=32, UPD_DEPTH=4, DRAIN_CYCLES=2).
// Expected perf counts follow BR_PERF_CNT_EN as defined for the build.
module tb_branch_resolve_ctrl;

    logic clk = 1'b0;
    logic reset;
    int   checks   = 0;
    int   failures = 0;

`ifdef BR_PERF_CNT_EN
    localparam logic [31:0] EXP_BR  = 32'd10;
    localparam logic [31:0] EXP_MIS = 32'd3;
`else
    localparam logic [31:0] EXP_BR  = 32'd0;
    localparam logic [31:0] EXP_MIS = 32'd0;
`endif

    always #5 clk = ~clk;

    branch_resolve_ctrl_if #(.PC_W(32)) bus ();

    branch_resolve_ctrl #(
        .PC_W         (32),
        .UPD_DEPTH    (4),
        .DRAIN_CYCLES (2)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Mixed correct/mispredicted branches, including PC wrap and a prediction
    // that equals the fall-through PC.
    logic [31:0] v_pc    [10] = '{32'h3000, 32'h3004, 32'hFFFF_FFFC, 32'h3008, 32'h300C,
                                  32'h3010, 32'h3014, 32'h3018,      32'h301C, 32'h3020};
    logic        v_tk    [10] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    logic [31:0] v_tgt   [10] = '{32'h3100, 32'h3200, 32'h0000_0010, 32'h3300, 32'h3350,
                                  32'h3400, 32'h3018, 32'h3450,      32'h3500, 32'h3550};
    logic        v_hit   [10] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    logic        v_ptk   [10] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    logic [31:0] v_ptgt  [10] = '{32'h0,    32'h3200, 32'h0000_0008, 32'h300C, 32'h0,
                                  32'h3400, 32'h0,    32'h9999,      32'h3600, 32'h0};
    logic        v_mis   [10] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [31:0] v_rpc   [10] = '{32'h0, 32'h0, 32'h0000_0000, 32'h0, 32'h0,
                                  32'h3400, 32'h0, 32'h0,      32'h3500, 32'h0};

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        bus.ex_valid       = 1'b0;
        bus.ex_branch      = 1'b0;
        bus.ex_pc          = '0;
        bus.ex_taken       = 1'b0;
        bus.ex_target      = '0;
        bus.ex_pred_hit    = 1'b0;
        bus.ex_pred_taken  = 1'b0;
        bus.ex_pred_target = '0;
    endtask

    task automatic drive_br(input logic [31:0] pc, input logic tk, input logic [31:0] tgt,
                            input logic hit, input logic ptk, input logic [31:0] ptgt);
        bus.ex_valid       = 1'b1;
        bus.ex_branch      = 1'b1;
        bus.ex_pc          = pc;
        bus.ex_taken       = tk;
        bus.ex_target      = tgt;
        bus.ex_pred_hit    = hit;
        bus.ex_pred_taken  = ptk;
        bus.ex_pred_target = ptgt;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        bus.upd_ready = 1'b0;
        drive_idle();
        repeat (2) step();
        checks++; if (bus.redirect_valid !== 1'b0) begin failures++; $display("FAIL rst_redirect_valid got=%b exp=0", bus.redirect_valid); end
        checks++; if (bus.flush_if_id !== 1'b0) begin failures++; $display("FAIL rst_flush_if_id got=%b exp=0", bus.flush_if_id); end
        checks++; if (bus.flush_id_ex !== 1'b0) begin failures++; $display("FAIL rst_flush_id_ex got=%b exp=0", bus.flush_id_ex); end
        checks++; if (bus.redirect_pc !== 32'h0) begin failures++; $display("FAIL rst_redirect_pc got=%h exp=0", bus.redirect_pc); end
        checks++; if (bus.upd_valid !== 1'b0) begin failures++; $display("FAIL rst_upd_valid got=%b exp=0", bus.upd_valid); end
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b exp=0", bus.busy); end
        checks++; if (bus.stall_req !== 1'b0) begin failures++; $display("FAIL rst_stall_req got=%b exp=0", bus.stall_req); end
        checks++; if (bus.perf_branches !== 32'h0) begin failures++; $display("FAIL rst_perf_branches got=%0d exp=0", bus.perf_branches); end
        reset = 1'b1;
        step();
    endtask

    task automatic test_correct_pred();
        bus.upd_ready = 1'b0;
        drive_br(32'h40, 1'b0, 32'h1234, 1'b0, 1'b0, 32'h0);
        #1;
        checks++; if (bus.stall_req !== 1'b0) begin failures++; $display("FAIL t1_stall got=%b exp=0", bus.stall_req); end
        step();
        drive_idle();
        checks++; if (bus.redirect_valid !== 1'b0) begin failures++; $display("FAIL t1_redirect_valid got=%b exp=0", bus.redirect_valid); end
        checks++; if (bus.flush_if_id !== 1'b0) begin failures++; $display("FAIL t1_flush_if_id got=%b exp=0", bus.flush_if_id); end
        checks++; if (bus.upd_valid !== 1'b1) begin failures++; $display("FAIL t1_upd_valid got=%b exp=1", bus.upd_valid); end
        checks++; if (bus.upd_pc !== 32'h40) begin failures++; $display("FAIL t1_upd_pc got=%h exp=00000040", bus.upd_pc); end
        checks++; if (bus.upd_taken !== 1'b0) begin failures++; $display("FAIL t1_upd_taken got=%b exp=0", bus.upd_taken); end
        checks++; if (bus.upd_target !== 32'h1234) begin failures++; $display("FAIL t1_upd_target got=%h exp=00001234", bus.upd_target); end
        bus.upd_ready = 1'b1;
        step();
        checks++; if (bus.upd_valid !== 1'b0) begin failures++; $display("FAIL t1_pop_upd_valid got=%b exp=0", bus.upd_valid); end
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL t1_busy got=%b exp=0", bus.busy); end
    endtask

    task automatic test_mispredict_target();
        bus.upd_ready = 1'b1;
        drive_br(32'h80, 1'b1, 32'h200, 1'b1, 1'b1, 32'h100);
        step();
        drive_idle();
        checks++; if (bus.redirect_valid !== 1'b1) begin failures++; $display("FAIL t2_redirect_valid got=%b exp=1", bus.redirect_valid); end
        checks++; if (bus.redirect_pc !== 32'h200) begin failures++; $display("FAIL t2_redirect_pc got=%h exp=00000200", bus.redirect_pc); end
        checks++; if (bus.flush_if_id !== 1'b1) begin failures++; $display("FAIL t2_flush_if_id got=%b exp=1", bus.flush_if_id); end
        checks++; if (bus.flush_id_ex !== 1'b1) begin failures++; $display("FAIL t2_flush_id_ex got=%b exp=1", bus.flush_id_ex); end
        checks++; if (bus.upd_pc !== 32'h80) begin failures++; $display("FAIL t2_upd_pc got=%h exp=00000080", bus.upd_pc); end
        step();
        checks++; if (bus.redirect_valid !== 1'b0) begin failures++; $display("FAIL t2_redirect_1cyc got=%b exp=0", bus.redirect_valid); end
        checks++; if (bus.flush_id_ex !== 1'b0) begin failures++; $display("FAIL t2_flush_1cyc got=%b exp=0", bus.flush_id_ex); end
        checks++; if (bus.busy !== 1'b1) begin failures++; $display("FAIL t2_busy_drain got=%b exp=1", bus.busy); end
        step();
        checks++; if (bus.busy !== 1'b1) begin failures++; $display("FAIL t2_busy_drain2 got=%b exp=1", bus.busy); end
        step();
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL t2_busy_idle got=%b exp=0", bus.busy); end
    endtask

    task automatic test_mispredict_dir_drain();
        bus.upd_ready = 1'b0;
        drive_br(32'h80, 1'b0, 32'h300, 1'b1, 1'b1, 32'h100);
        step();
        checks++; if (bus.redirect_valid !== 1'b1) begin failures++; $display("FAIL t3_redirect_valid got=%b exp=1", bus.redirect_valid); end
        checks++; if (bus.redirect_pc !== 32'h84) begin failures++; $display("FAIL t3_redirect_pc got=%h exp=00000084", bus.redirect_pc); end
        // Wrong-path branch held through REDIRECT and both DRAIN cycles.
        drive_br(32'h500, 1'b1, 32'h600, 1'b0, 1'b0, 32'h0);
        #1;
        checks++; if (bus.stall_req !== 1'b0) begin failures++; $display("FAIL t3_stall_redirect got=%b exp=0", bus.stall_req); end
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if (bus.redirect_valid !== 1'b0) begin failures++; $display("FAIL t3_drain_redirect[%0d] got=%b exp=0", i, bus.redirect_valid); end
        end
        drive_idle();
        checks++; if (bus.upd_pc !== 32'h80) begin failures++; $display("FAIL t3_upd_pc got=%h exp=00000080", bus.upd_pc); end
        checks++; if (bus.upd_taken !== 1'b0) begin failures++; $display("FAIL t3_upd_taken got=%b exp=0", bus.upd_taken); end
        checks++; if (bus.upd_target !== 32'h300) begin failures++; $display("FAIL t3_upd_target got=%h exp=00000300", bus.upd_target); end
        bus.upd_ready = 1'b1;
        step();
        checks++; if (bus.upd_valid !== 1'b0) begin failures++; $display("FAIL t3_single_entry got=%b exp=0", bus.upd_valid); end
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL t3_busy got=%b exp=0", bus.busy); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_pc;
        bus.upd_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive_br(32'h1000 + 32'(4 * i), 1'b0, 32'h1100 + 32'(4 * i), 1'b0, 1'b0, 32'h0);
            #1;
            checks++; if (bus.stall_req !== 1'b0) begin failures++; $display("FAIL t4_stall_fill[%0d] got=%b exp=0", i, bus.stall_req); end
            step();
        end
        drive_br(32'h1010, 1'b0, 32'h1110, 1'b0, 1'b0, 32'h0);
        #1;
        checks++; if (bus.stall_req !== 1'b1) begin failures++; $display("FAIL t4_stall_5th got=%b exp=1", bus.stall_req); end
        step();
        checks++; if (bus.stall_req !== 1'b1) begin failures++; $display("FAIL t4_stall_hold got=%b exp=1", bus.stall_req); end
        checks++; if (bus.upd_pc !== 32'h1000) begin failures++; $display("FAIL t4_head_hold got=%h exp=00001000", bus.upd_pc); end
        bus.upd_ready = 1'b1;
        #1;
        checks++; if (bus.stall_req !== 1'b1) begin failures++; $display("FAIL t4_stall_on_pop got=%b exp=1", bus.stall_req); end
        step();
        checks++; if (bus.stall_req !== 1'b0) begin failures++; $display("FAIL t4_stall_release got=%b exp=0", bus.stall_req); end
        checks++; if (bus.upd_pc !== 32'h1004) begin failures++; $display("FAIL t4_pop1 got=%h exp=00001004", bus.upd_pc); end
        step();
        drive_idle();
        for (int i = 0; i < 3; i++) begin
            exp_pc = 32'h1008 + 32'(4 * i);
            checks++; if (bus.upd_pc !== exp_pc) begin failures++; $display("FAIL t4_order[%0d] got=%h exp=%h", i, bus.upd_pc, exp_pc); end
            checks++; if (bus.upd_target !== exp_pc + 32'h100) begin failures++; $display("FAIL t4_tgt[%0d] got=%h exp=%h", i, bus.upd_target, exp_pc + 32'h100); end
            step();
        end
        checks++; if (bus.upd_valid !== 1'b0) begin failures++; $display("FAIL t4_drained got=%b exp=0", bus.upd_valid); end
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL t4_busy got=%b exp=0", bus.busy); end
    endtask

    task automatic test_reset_in_drain();
        bus.upd_ready = 1'b0;
        drive_br(32'h2000, 1'b0, 32'h2010, 1'b0, 1'b0, 32'h0);
        step();
        drive_br(32'h2100, 1'b1, 32'h2200, 1'b0, 1'b0, 32'h0);
        step();
        drive_idle();
        checks++; if (bus.redirect_valid !== 1'b1) begin failures++; $display("FAIL t5_redirect got=%b exp=1", bus.redirect_valid); end
        step();
        checks++; if (bus.busy !== 1'b1) begin failures++; $display("FAIL t5_busy_drain got=%b exp=1", bus.busy); end
        reset = 1'b0;
        step();
        checks++; if (bus.redirect_valid !== 1'b0) begin failures++; $display("FAIL t5_redirect_valid got=%b exp=0", bus.redirect_valid); end
        checks++; if (bus.flush_if_id !== 1'b0) begin failures++; $display("FAIL t5_flush_if_id got=%b exp=0", bus.flush_if_id); end
        checks++; if (bus.redirect_pc !== 32'h0) begin failures++; $display("FAIL t5_redirect_pc got=%h exp=0", bus.redirect_pc); end
        checks++; if (bus.upd_valid !== 1'b0) begin failures++; $display("FAIL t5_upd_valid got=%b exp=0", bus.upd_valid); end
        checks++; if (bus.upd_pc !== 32'h0) begin failures++; $display("FAIL t5_upd_pc got=%h exp=0", bus.upd_pc); end
        checks++; if (bus.upd_target !== 32'h0) begin failures++; $display("FAIL t5_upd_target got=%h exp=0", bus.upd_target); end
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL t5_busy got=%b exp=0", bus.busy); end
        checks++; if (bus.perf_mispred !== 32'h0) begin failures++; $display("FAIL t5_perf_mispred got=%0d exp=0", bus.perf_mispred); end
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if (bus.redirect_valid !== 1'b0) begin failures++; $display("FAIL t5_no_redirect[%0d] got=%b exp=0", i, bus.redirect_valid); end
        end
        // FSM must be IDLE: a fresh mispredict redirects immediately.
        bus.upd_ready = 1'b1;
        drive_br(32'h2300, 1'b1, 32'h2400, 1'b0, 1'b0, 32'h0);
        step();
        drive_idle();
        checks++; if (bus.redirect_valid !== 1'b1) begin failures++; $display("FAIL t5_idle_redirect got=%b exp=1", bus.redirect_valid); end
        checks++; if (bus.redirect_pc !== 32'h2400) begin failures++; $display("FAIL t5_idle_redirect_pc got=%h exp=00002400", bus.redirect_pc); end
        repeat (3) step();
    endtask

    task automatic test_perf();
        reset = 1'b0;
        drive_idle();
        step();
        reset = 1'b1;
        step();
        bus.upd_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            drive_br(v_pc[i], v_tk[i], v_tgt[i], v_hit[i], v_ptk[i], v_ptgt[i]);
            step();
            drive_idle();
            checks++; if (bus.redirect_valid !== v_mis[i]) begin failures++; $display("FAIL t6_mispredict[%0d] got=%b exp=%b", i, bus.redirect_valid, v_mis[i]); end
            if (v_mis[i]) begin
                checks++; if (bus.redirect_pc !== v_rpc[i]) begin failures++; $display("FAIL t6_redirect_pc[%0d] got=%h exp=%h", i, bus.redirect_pc, v_rpc[i]); end
                repeat (3) step();
            end
        end
        repeat (2) step();
        checks++; if (bus.perf_branches !== EXP_BR) begin failures++; $display("FAIL t6_perf_branches got=%0d exp=%0d", bus.perf_branches, EXP_BR); end
        checks++; if (bus.perf_mispred !== EXP_MIS) begin failures++; $display("FAIL t6_perf_mispred got=%0d exp=%0d", bus.perf_mispred, EXP_MIS); end
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL t6_busy got=%b exp=0", bus.busy); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "simulation time limit reached");
    end

    initial begin
        test_reset();
        test_correct_pred();
        test_mispredict_target();
        test_mispredict_dir_drain();
        test_back_to_back();
        test_reset_in_drain();
        test_perf();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
